// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-stage RISC-V CPU: writeback select encoding,
// CSR addresses of the GPIO registers, and the default datapath width.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_GPIO_OUT = 12'hF00;
  localparam logic [11:0] CSR_GPIO_IN  = 12'hF02;

  // Source of the register-file write data, decided in EX.
  typedef enum logic [1:0] {
    RSEL_ZERO = 2'b00,
    RSEL_LUI  = 2'b01,
    RSEL_ALU  = 2'b10,
    RSEL_CSR  = 2'b11
  } regsel_t;

  // Control half of the EX/WB pipeline register.
  typedef struct packed {
    logic       regwrite;
    logic [4:0] rd;
  } wb_ctrl_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for the asynchronous GPIO input bus.
// Only the last stage is meant to be observed by downstream logic.
module gpio_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [DEPTH];

  // Shift the input through the chain every cycle; clear all stages on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these stages are discrete flops, not a RAM array, so clearing
      // them in reset is cheap and gives a known value while the chain refills.
      for (int i = 0; i < DEPTH; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the value its
      // predecessor held before the edge; blocking here would collapse the chain.
      sync_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: EX/WB pipeline register, register-file write data select,
// GPIO output register, synchronized GPIO input and WB->EX forwarding.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN        = cpu_pkg::XLEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwrite_EX,
  input  regsel_t         regsel_EX,
  input  logic            GPIO_we_EX,
  input  logic [4:0]      rd_EX,
  input  logic [4:0]      rs1_EX,
  input  logic [4:0]      rs2_EX,
  input  logic [XLEN-1:0] alu_result_EX,
  input  logic [19:0]     imm20_EX,
  input  logic [XLEN-1:0] csr_wdata_EX,
  input  logic [XLEN-1:0] gpio_in,
  output logic            rf_we_WB,
  output logic [4:0]      rf_waddr_WB,
  output logic [XLEN-1:0] rf_wdata_WB,
  output logic [XLEN-1:0] gpio_out,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_data
);

  wb_ctrl_t        ctrl_q;
  logic [XLEN-1:0] wdata_d, wdata_q;
  logic [XLEN-1:0] gpio_out_d, gpio_out_q;
  logic [XLEN-1:0] gpio_in_sync;

  gpio_sync #(
    .WIDTH (XLEN),
    .DEPTH (SYNC_STAGES)
  ) u_gpio_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gpio_in),
    .q_o (gpio_in_sync)
  );

  // Pick the writeback data word in EX so WB only has to register it.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch can be inferred if the select ever takes an unlisted value.
    wdata_d = '0;
    unique case (regsel_EX)
      RSEL_ALU:  wdata_d = alu_result_EX;
      RSEL_LUI:  wdata_d = XLEN'({imm20_EX, 12'h000});
      RSEL_CSR:  wdata_d = gpio_in_sync;
      RSEL_ZERO: wdata_d = '0;
      default:   wdata_d = '0;
    endcase
  end

  // GPIO output register loads on a csrrw to the output CSR, holds otherwise.
  always_comb begin
    gpio_out_d = gpio_out_q;
    if (GPIO_we_EX) gpio_out_d = csr_wdata_EX;
  end

  // EX/WB pipeline register and GPIO output register; reset wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      wdata_q    <= '0;
      gpio_out_q <= '0;
    end else begin
      ctrl_q.regwrite <= regwrite_EX;
      ctrl_q.rd       <= rd_EX;
      wdata_q         <= wdata_d;
      gpio_out_q      <= gpio_out_d;
    end
  end

  // Register-file write port; x0 is hard-wired so it is never written.
  assign rf_we_WB    = ctrl_q.regwrite && (ctrl_q.rd != 5'd0);
  assign rf_waddr_WB = ctrl_q.rd;
  assign rf_wdata_WB = wdata_q;
  assign gpio_out    = gpio_out_q;

  // Forwarding replaces an EX source operand with the result being written now.
  assign fwd_rs1_hit = rf_we_WB && (rf_waddr_WB == rs1_EX);
  assign fwd_rs2_hit = rf_we_WB && (rf_waddr_WB == rs2_EX);
  assign fwd_data    = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected WB results are queued when an
// instruction is driven into EX and compared when it appears at WB.
module tb_wb_stage;
  import cpu_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_EX;
  regsel_t     regsel_EX;
  logic        GPIO_we_EX;
  logic [4:0]  rd_EX, rs1_EX, rs2_EX;
  logic [31:0] alu_result_EX;
  logic [19:0] imm20_EX;
  logic [31:0] csr_wdata_EX;
  logic [31:0] gpio_in;
  logic        rf_we_WB;
  logic [4:0]  rf_waddr_WB;
  logic [31:0] rf_wdata_WB;
  logic [31:0] gpio_out;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_data;

  wb_stage #(.XLEN(32), .SYNC_STAGES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .regwrite_EX   (regwrite_EX),
    .regsel_EX     (regsel_EX),
    .GPIO_we_EX    (GPIO_we_EX),
    .rd_EX         (rd_EX),
    .rs1_EX        (rs1_EX),
    .rs2_EX        (rs2_EX),
    .alu_result_EX (alu_result_EX),
    .imm20_EX      (imm20_EX),
    .csr_wdata_EX  (csr_wdata_EX),
    .gpio_in       (gpio_in),
    .rf_we_WB      (rf_we_WB),
    .rf_waddr_WB   (rf_waddr_WB),
    .rf_wdata_WB   (rf_wdata_WB),
    .gpio_out      (gpio_out),
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs2_hit   (fwd_rs2_hit),
    .fwd_data      (fwd_data)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  bit          cur_valid = 0;
  int          assertions = 0;
  int          failures = 0;
  logic [31:0] gpio_model = '0;
  logic [31:0] gin_old = '0, gin_new = '0;
  int          gin_chg = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one EX instruction, check forwarding against the current WB entry,
  // clock it, then check the WB outputs against the scoreboard.
  task automatic cycle(input bit r, input bit rw, input regsel_t rs, input logic [4:0] rd,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] alu,
                       input logic [19:0] imm, input logic [31:0] cw, input bit gwe);
    exp_t        e;
    logic [31:0] d;
    rst = r; regwrite_EX = rw; regsel_EX = rs; rd_EX = rd; rs1_EX = s1; rs2_EX = s2;
    alu_result_EX = alu; imm20_EX = imm; csr_wdata_EX = cw; GPIO_we_EX = gwe;
    case (rs)
      RSEL_ALU: d = alu;
      RSEL_LUI: d = {imm, 12'h000};
      RSEL_CSR: d = (edge_cnt + 1 >= gin_chg + S) ? gin_new : gin_old;
      default:  d = 32'h0;
    endcase
    e.we    = !r && rw && (rd != 5'd0);
    e.waddr = r ? 5'd0 : rd;
    e.wdata = r ? 32'h0 : d;
    sb.push_back(e);
    #1;
    if (cur_valid) begin
      check("fwd_rs1_hit", {31'b0, fwd_rs1_hit}, {31'b0, cur.we && (cur.waddr == s1)});
      check("fwd_rs2_hit", {31'b0, fwd_rs2_hit}, {31'b0, cur.we && (cur.waddr == s2)});
    end
    if (r) gpio_model = '0;
    else if (gwe) gpio_model = cw;
    @(posedge clk);
    #1;
    cur = sb.pop_front();
    cur_valid = 1;
    check("rf_we_WB", {31'b0, rf_we_WB}, {31'b0, cur.we});
    check("rf_waddr_WB", {27'b0, rf_waddr_WB}, {27'b0, cur.waddr});
    check("rf_wdata_WB", rf_wdata_WB, cur.wdata);
    check("fwd_data", fwd_data, cur.wdata);
    check("gpio_out", gpio_out, gpio_model);
  endtask

  initial begin
    gpio_in = '0;
    // Reset for two cycles with a GPIO write and a register write pending.
    for (int i = 0; i < 2; i++)
      cycle(1, 1, RSEL_ALU, 5'd5, 5'd0, 5'd0, 32'h1111_1111, 20'h0, 32'hFFFF_FFFF, 1);
    // First cycle after release: nothing in flight.
    cycle(0, 0, RSEL_ZERO, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0, 0);

    // ALU writeback, then LUI with rs1 matching the ALU result in WB.
    cycle(0, 1, RSEL_ALU, 5'd5, 5'd1, 5'd2, 32'hDEAD_BEEF, 20'h0, 32'h0, 0);
    cycle(0, 1, RSEL_LUI, 5'd3, 5'd5, 5'd3, 32'h0, 20'h12345, 32'h0, 0);
    cycle(0, 0, RSEL_ALU, 5'd4, 5'd4, 5'd3, 32'h0BAD_F00D, 20'h0, 32'h0, 0);

    // GPIO write for one cycle, then hold for ten while csr data changes.
    cycle(0, 0, RSEL_ZERO, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0000_0ABC, 1);
    for (int i = 0; i < 10; i++)
      cycle(0, 0, RSEL_ZERO, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, $urandom, 0);

    // GPIO input latency: change applied between edges, RSEL_CSR every cycle.
    gin_old = 32'h0; gin_new = 32'h0003_FFFF; gin_chg = edge_cnt + 1;
    gpio_in = gin_new;
    for (int i = 0; i < S + 3; i++)
      cycle(0, 1, RSEL_CSR, 5'd10, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0, 0);

    // Write to x0 is suppressed; no forwarding from it even with rs=0.
    cycle(0, 1, RSEL_ALU, 5'd0, 5'd0, 5'd0, 32'h0000_1234, 20'h0, 32'h0, 0);
    cycle(0, 1, RSEL_ALU, 5'd7, 5'd0, 5'd0, 32'hCAFE_0007, 20'h0, 32'h0, 0);
    // rd=7 is in WB: rs1=7 hits, rs2=8 does not.
    cycle(0, 0, RSEL_ZERO, 5'd0, 5'd7, 5'd8, 32'h0, 20'h0, 32'h0, 0);

    // Back-to-back GPIO writes: last one wins, one update per cycle.
    cycle(0, 0, RSEL_ZERO, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0000_0011, 1);
    cycle(0, 0, RSEL_ZERO, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0000_0022, 1);

    // Reset mid-operation: in-flight instruction and simultaneous GPIO write dropped.
    cycle(0, 1, RSEL_ALU, 5'd9, 5'd0, 5'd0, 32'h9999_9999, 20'h0, 32'h0, 0);
    cycle(1, 1, RSEL_ALU, 5'd9, 5'd9, 5'd9, 32'h7777_7777, 20'h0, 32'h0000_0077, 1);
    cycle(0, 0, RSEL_ZERO, 5'd0, 5'd9, 5'd9, 32'h0, 20'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
